tmds_decoder: RTL and testbench

Receive-side TMDS channel decoder for the DVI/HDMI input path. It takes raw 10-bit parallel words from the channel deserializer, which has arbitrary bit alignment. It finds symbol alignment by locking onto runs of control tokens during blanking, then decodes 10b symbols back into 8-bit pixel data or 2-bit control (hsync/vsync). One instance per TMDS channel; outputs feed the capture/timing-recovery logic.

---
 rtl/tmds_decoder.sv | 143 ++++++++++++++
 tb/tb_tmds_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: finds 10b symbol alignment from control-token
// runs during blanking, then decodes symbols into pixel bytes or sync bits.
module tmds_decoder #(
  parameter int unsigned LOCK_COUNT     = 16,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw_in,
  output logic [7:0] data_out,
  output logic       de_out,
  output logic [1:0] ctrl_out,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TW = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned GW = $clog2(LOSS_TIMEOUT + 1);

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t        state, state_nxt;
  logic [9:0]    raw_prev;
  logic [MW-1:0] match_cnt, match_nxt, match_inc;
  logic [TW-1:0] search_timer, timer_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt, gap_inc;
  logic [3:0]    offset_nxt;

  logic [19:0]   combined;
  logic [9:0]    window;
  logic          is_ctrl;
  logic [1:0]    tok_bits;
  logic [7:0]    m;
  logic [7:0]    dec;

  logic [7:0]    data_nxt;
  logic          de_nxt;
  logic [1:0]    ctrl_nxt;
  logic          locked_nxt;

  // Window at the current offset; offset 0 is exactly the previous word.
  assign combined  = {raw_in, raw_prev};
  assign window    = 10'(combined >> offset);
  assign match_inc = match_cnt + MW'(1);
  assign gap_inc   = gap_cnt + GW'(1);

  always_comb begin
    is_ctrl  = 1'b0;
    tok_bits = 2'b00;
    case (window)
      10'b1101010100: begin is_ctrl = 1'b1; tok_bits = 2'b00; end
      10'b0010101011: begin is_ctrl = 1'b1; tok_bits = 2'b01; end
      10'b0101010100: begin is_ctrl = 1'b1; tok_bits = 2'b10; end
      10'b1010101011: begin is_ctrl = 1'b1; tok_bits = 2'b11; end
      default: ;
    endcase
  end

  // Undo optional inversion (bit 9), then XOR/XNOR chaining (bit 8).
  always_comb begin
    m      = window[9] ? ~window[7:0] : window[7:0];
    dec    = 8'h00;
    dec[0] = m[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = window[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
    end
  end

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    match_nxt  = match_cnt;
    timer_nxt  = search_timer;
    gap_nxt    = gap_cnt;
    data_nxt   = 8'h00;
    de_nxt     = 1'b0;
    ctrl_nxt   = 2'b00;
    locked_nxt = 1'b0;

    case (state)
      S_SEARCH: begin
        match_nxt = is_ctrl ? match_inc : '0;
        timer_nxt = search_timer + TW'(1);
        // A completed run takes priority over the offset timeout.
        if (is_ctrl && (match_inc == MW'(LOCK_COUNT))) begin
          state_nxt = S_LOCKED;
          match_nxt = '0;
          timer_nxt = '0;
          gap_nxt   = '0;
        end else if (search_timer == TW'(SEARCH_TIMEOUT - 1)) begin
          offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          match_nxt  = '0;
          timer_nxt  = '0;
        end
      end
      S_LOCKED: begin
        gap_nxt = is_ctrl ? '0 : gap_inc;
        if (!is_ctrl && (gap_inc == GW'(LOSS_TIMEOUT))) begin
          state_nxt = S_SEARCH;
          match_nxt = '0;
          timer_nxt = '0;
          gap_nxt   = '0;
        end
      end
    endcase

    if (state_nxt == S_LOCKED) begin
      locked_nxt = 1'b1;
      de_nxt     = ~is_ctrl;
      data_nxt   = is_ctrl ? 8'h00 : dec;
      ctrl_nxt   = is_ctrl ? tok_bits : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_SEARCH;
      raw_prev     <= '0;
      offset       <= '0;
      match_cnt    <= '0;
      search_timer <= '0;
      gap_cnt      <= '0;
      data_out     <= '0;
      de_out       <= 1'b0;
      ctrl_out     <= '0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nxt;
      raw_prev     <= raw_in;
      offset       <= offset_nxt;
      match_cnt    <= match_nxt;
      search_timer <= timer_nxt;
      gap_cnt      <= gap_nxt;
      data_out     <= data_nxt;
      de_out       <= de_nxt;
      ctrl_out     <= ctrl_nxt;
      locked       <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder with short lock/search/loss timeouts.
module tb_tmds_decoder;

  logic       clk;
  logic       rst_n;
  logic [9:0] raw_in;
  logic [7:0] data_out;
  logic       de_out;
  logic [1:0] ctrl_out;
  logic       locked;
  logic [3:0] offset;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] TOK0 = 10'h354;

  tmds_decoder #(
    .LOCK_COUNT(4),
    .SEARCH_TIMEOUT(32),
    .LOSS_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .data_out(data_out),
    .de_out(de_out),
    .ctrl_out(ctrl_out),
    .locked(locked),
    .offset(offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] tok(input int i);
    case (i)
      0: return 10'b1101010100;
      1: return 10'b0010101011;
      2: return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference TMDS encoder (transition minimisation, caller picks inversion).
  function automatic logic [9:0] tmds_encode(input logic [7:0] d, input logic inv);
    int n1;
    logic use_xnor;
    logic [7:0] qm;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    return {inv, ~use_xnor, inv ? ~qm : qm};
  endfunction

  task automatic step(input logic [9:0] w);
    raw_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    raw_in = 10'h000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(10'($urandom));
      checks++;
      if ({data_out, de_out, ctrl_out, locked, offset} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold: got %h required 0000", {data_out, de_out, ctrl_out, locked, offset});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) step(10'h000);
    checks++;
    if (offset !== 4'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre_timeout: offset %0d locked %b required 0 0", offset, locked);
    end
    step(10'h000);
    checks++;
    if (offset !== 4'd1) begin
      errors++;
      $display("FAIL reset_timeout_advance: offset %0d required 1", offset);
    end
  endtask

  task automatic test_aligned_lock();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(TOK0);
      if (i == 4) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL aligned_early_lock: locked %b required 0", locked);
        end
      end
      if (i == 5) begin
        checks++;
        if ({locked, de_out, ctrl_out, data_out} !== 12'h800) begin
          errors++;
          $display("FAIL aligned_lock_edge: got %h required 800", {locked, de_out, ctrl_out, data_out});
        end
      end
    end
    step(10'h100);
    step(10'h200);
    checks++;
    if ({locked, de_out, ctrl_out, data_out} !== 12'hC00) begin
      errors++;
      $display("FAIL aligned_data_00: got %h required c00", {locked, de_out, ctrl_out, data_out});
    end
    step(TOK0);
    checks++;
    if ({locked, de_out, ctrl_out, data_out} !== 12'hCFF) begin
      errors++;
      $display("FAIL aligned_data_ff: got %h required cff", {locked, de_out, ctrl_out, data_out});
    end
    checks++;
    if (offset !== 4'd0) begin
      errors++;
      $display("FAIL aligned_offset: got %0d required 0", offset);
    end
  endtask

  task automatic test_misaligned();
    logic [9:0]  sym [0:199];
    logic [7:0]  byt [0:199];
    logic [2:0]  hi;
    logic [11:0] exp_v;
    int lock_step, g, p, k;
    for (int j = 0; j < 200; j++) begin
      g = j / 60;
      p = j % 60;
      if (p < 20) begin
        sym[j] = tok(g % 4);
        byt[j] = 8'h00;
      end else begin
        byt[j] = 8'(j * 37 + 11);
        sym[j] = tmds_encode(byt[j], (j % 3) == 0);
      end
    end
    do_reset();
    hi = 3'b000;
    lock_step = 0;
    // Serial stream slipped by 3 bits: each raw word straddles two symbols.
    for (int n = 1; n <= 187; n++) begin
      step({sym[n-1][6:0], hi});
      hi = sym[n-1][9:7];
      if (n == 32 || n == 64 || n == 96) begin
        checks++;
        if (offset !== 4'(n / 32)) begin
          errors++;
          $display("FAIL misalign_offset_step%0d: got %0d required %0d", n, offset, n / 32);
        end
      end
      if (lock_step == 0 && locked === 1'b1) lock_step = n;
      if (lock_step != 0) begin
        k = n - 2;
        if ((k % 60) < 20) exp_v = {1'b1, 1'b0, 2'(((k / 60) % 4)), 8'h00};
        else exp_v = {1'b1, 1'b1, 2'b00, byt[k]};
        checks++;
        if ({locked, de_out, ctrl_out, data_out} !== exp_v) begin
          errors++;
          $display("FAIL misalign_decode_sym%0d: got %h required %h", k, {locked, de_out, ctrl_out, data_out}, exp_v);
        end
      end
    end
    checks++;
    if (lock_step != 125 || offset !== 4'd3) begin
      errors++;
      $display("FAIL misalign_lock: step %0d offset %0d required 125 3", lock_step, offset);
    end
  endtask

  task automatic test_broken_run();
    logic [9:0] seq [0:8];
    seq = '{TOK0, TOK0, TOK0, 10'h100, TOK0, TOK0, TOK0, TOK0, 10'h200};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(seq[i]);
      if (i == 4 || i == 7) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL broken_no_lock_step%0d: locked %b required 0", i + 1, locked);
        end
      end
    end
    checks++;
    if ({locked, de_out, ctrl_out} !== 4'b1000) begin
      errors++;
      $display("FAIL broken_relock: got %b required 1000", {locked, de_out, ctrl_out});
    end
  endtask

  task automatic test_loss_of_lock();
    logic [9:0] prev_sym;
    logic [9:0] s;
    do_reset();
    for (int i = 0; i < 32; i++) step(10'h000);
    prev_sym = 10'h000;
    // Symbols sent at offset 1: raw word = {sym[8:0], previous sym[9]}.
    for (int n = 1; n <= 73; n++) begin
      s = (n <= 4 || (n >= 69 && n <= 72)) ? TOK0 : 10'h200;
      step({s[8:0], prev_sym[9]});
      prev_sym = s;
      if (n == 5) begin
        checks++;
        if (locked !== 1'b1 || offset !== 4'd1) begin
          errors++;
          $display("FAIL loss_initial_lock: locked %b offset %0d required 1 1", locked, offset);
        end
      end
      if (n == 68) begin
        checks++;
        if ({locked, de_out, ctrl_out, data_out} !== 12'hCFF) begin
          errors++;
          $display("FAIL loss_gap63: got %h required cff", {locked, de_out, ctrl_out, data_out});
        end
      end
      if (n == 69) begin
        checks++;
        if ({locked, de_out, ctrl_out, data_out, offset} !== 16'h0001) begin
          errors++;
          $display("FAIL loss_drop: got %h required 0001", {locked, de_out, ctrl_out, data_out, offset});
        end
      end
      if (n == 72) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL loss_relock_early: locked %b required 0", locked);
        end
      end
    end
    checks++;
    if ({locked, de_out, ctrl_out, offset} !== 8'h81) begin
      errors++;
      $display("FAIL loss_relock: got %h required 81", {locked, de_out, ctrl_out, offset});
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    for (int i = 0; i < 4; i++) step(TOK0);
    step(10'h200);
    step(10'h200);
    step(10'h200);
    checks++;
    if ({locked, de_out, data_out} !== 10'h3FF) begin
      errors++;
      $display("FAIL midlock_pre: got %h required 3ff", {locked, de_out, data_out});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, de_out, ctrl_out, locked, offset} !== 16'h0000) begin
      errors++;
      $display("FAIL midlock_async_clear: got %h required 0000", {data_out, de_out, ctrl_out, locked, offset});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(i <= 4 ? TOK0 : 10'h200);
      if (i == 4) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL midlock_relock_early: locked %b required 0", locked);
        end
      end
    end
    checks++;
    if ({locked, de_out, ctrl_out} !== 4'b1000) begin
      errors++;
      $display("FAIL midlock_relock: got %b required 1000", {locked, de_out, ctrl_out});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = 10'h000;
    test_reset();
    test_aligned_lock();
    test_misaligned();
    test_broken_run();
    test_loss_of_lock();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
